// File: rtl/umix_seq_alu.sv
// umix_seq_alu: add/nand in one cycle, iterative shift-add multiply and restoring divide with start/done handshake
module umix_seq_alu #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             init,
   input  logic             start,
   input  logic [1:0]       alu_mode,
   input  logic [WIDTH-1:0] alu_x,
   input  logic [WIDTH-1:0] alu_y,
   output logic [WIDTH-1:0] alu_result,
   output logic             busy,
   output logic             done,
   output logic             div_zero
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
   state_t           state_q, state_d;
   logic [1:0]       mode_q, mode_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, res_q, res_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             dz_q, dz_d;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH-1:0] rem_sub, rem_nxt, mul_acc;
   logic             ge, accept, is_mul;
   always_comb begin
      rem_sh  = {acc_q, a_q[WIDTH-1]};
      ge      = rem_sh >= {1'b0, b_q};
      rem_sub = rem_sh[WIDTH-1:0] - b_q;
      rem_nxt = ge ? rem_sub : rem_sh[WIDTH-1:0];
      mul_acc = acc_q + (b_q[0] ? a_q : '0);
      is_mul  = mode_q == 2'b01;
      accept  = start && state_q != ITER;
      state_d = state_q;
      mode_d  = mode_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      res_d   = res_q;
      cnt_d   = cnt_q;
      dz_d    = dz_q;
      if (accept) begin
         mode_d = alu_mode;
         dz_d   = 1'b0;
         if (alu_mode == 2'b00 || alu_mode == 2'b11) begin
            res_d   = alu_mode == 2'b00 ? alu_x + alu_y : ~(alu_x & alu_y);
            state_d = DONE;
         end else begin
            a_d     = alu_x;
            b_d     = alu_y;
            acc_d   = '0;
            cnt_d   = CW'(WIDTH - 1);
            state_d = ITER;
         end
      end else if (state_q == ITER) begin
         // div shifts the dividend out of a_q's MSB and the quotient bits into its LSB
         a_d   = is_mul ? a_q << 1 : {a_q[WIDTH-2:0], ge};
         b_d   = is_mul ? b_q >> 1 : b_q;
         acc_d = is_mul ? mul_acc : rem_nxt;
         cnt_d = cnt_q - 1'b1;
         if (cnt_q == '0) begin
            state_d = DONE;
            res_d   = is_mul ? mul_acc : {a_q[WIDTH-2:0], ge};
            dz_d    = mode_q == 2'b10 && b_q == '0;
         end
      end else if (state_q == DONE) begin
         state_d = IDLE;
      end
   end
   always_ff @(posedge clk) begin
      if (init) begin
         state_q <= IDLE;
         mode_q  <= '0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
         dz_q    <= dz_d;
      end
   end
   assign alu_result = res_q;
   assign busy       = state_q == ITER;
   assign done       = state_q == DONE;
   assign div_zero   = dz_q;
endmodule

// File: tb/tb_umix_seq_alu.sv
// tb_umix_seq_alu: directed vector table plus hand-written busy-ignore and mid-op reset sequences
module tb_umix_seq_alu;
   logic        clk = 1'b0;
   logic        init, start;
   logic [1:0]  alu_mode;
   logic [31:0] alu_x, alu_y, alu_result;
   logic        busy, done, div_zero;
   int          checks = 0;
   int          errors = 0;
   typedef struct {
      logic [1:0]  mode;
      logic [31:0] x, y, res;
      logic        dz;
      int          lat, bcnt;
   } vec_t;
   vec_t vecs[10];
   umix_seq_alu #(.WIDTH(32)) dut (
      .clk(clk), .init(init), .start(start), .alu_mode(alu_mode),
      .alu_x(alu_x), .alu_y(alu_y), .alu_result(alu_result),
      .busy(busy), .done(done), .div_zero(div_zero)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask
   task automatic do_op(input logic [1:0] m, input logic [31:0] x, input logic [31:0] y,
                        output int lat, output int bcnt);
      @(negedge clk);
      start = 1'b1; alu_mode = m; alu_x = x; alu_y = y;
      @(posedge clk); #1;
      start = 1'b0; alu_mode = 2'($urandom); alu_x = $urandom; alu_y = $urandom;
      lat = 1; bcnt = 0;
      while (!done && lat < 100) begin
         if (busy) bcnt++;
         @(posedge clk); #1;
         lat++;
      end
   endtask
   initial begin
      int lat, bcnt;
      vecs[0] = '{2'b00, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 1'b0, 1, 0};
      vecs[1] = '{2'b11, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FFF0FFF, 1'b0, 1, 0};
      vecs[2] = '{2'b01, 32'h00010000, 32'h00010000, 32'h00000000, 1'b0, 33, 32};
      vecs[3] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 33, 32};
      vecs[4] = '{2'b10, 32'd100, 32'd7, 32'd14, 1'b0, 33, 32};
      vecs[5] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 33, 32};
      vecs[6] = '{2'b10, 32'hFFFFFFFE, 32'h00000002, 32'h7FFFFFFF, 1'b0, 33, 32};
      vecs[7] = '{2'b10, 32'd5, 32'd0, 32'hFFFFFFFF, 1'b1, 33, 32};
      vecs[8] = '{2'b00, 32'd1, 32'd1, 32'd2, 1'b0, 1, 0};
      vecs[9] = '{2'b01, 32'd12345, 32'd678, 32'd8369910, 1'b0, 33, 32};
      init = 1'b1; start = 1'b0; alu_mode = 2'b00; alu_x = '0; alu_y = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_result", alu_result, 32'h0);
      chk("rst_busy", {31'b0, busy}, 32'h0);
      chk("rst_done", {31'b0, done}, 32'h0);
      chk("rst_dz", {31'b0, div_zero}, 32'h0);
      init = 1'b0;
      for (int i = 0; i < 10; i++) begin
         do_op(vecs[i].mode, vecs[i].x, vecs[i].y, lat, bcnt);
         chk($sformatf("v%0d_result", i), alu_result, vecs[i].res);
         chk($sformatf("v%0d_dz", i), {31'b0, div_zero}, {31'b0, vecs[i].dz});
         chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
         chk($sformatf("v%0d_busy_cycles", i), bcnt, vecs[i].bcnt);
      end
      @(posedge clk); #1;
      chk("done_pulse_drops", {31'b0, done}, 32'h0);
      chk("result_held", alu_result, 32'd8369910);
      // start during a multiply must not disturb it
      @(negedge clk);
      start = 1'b1; alu_mode = 2'b01; alu_x = 32'd3; alu_y = 32'd4;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 1;
      while (!done && lat < 100) begin
         if (lat == 5) begin
            @(negedge clk);
            start = 1'b1; alu_mode = 2'b00; alu_x = 32'd7; alu_y = 32'd9;
            @(posedge clk); #1;
            start = 1'b0;
         end else begin
            @(posedge clk); #1;
         end
         lat++;
      end
      chk("ignore_result", alu_result, 32'd12);
      chk("ignore_latency", lat, 33);
      // init mid-multiply
      @(negedge clk);
      start = 1'b1; alu_mode = 2'b01; alu_x = 32'd6; alu_y = 32'd7;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      init = 1'b1;
      @(posedge clk); #1;
      init = 1'b0;
      chk("midrst_busy", {31'b0, busy}, 32'h0);
      chk("midrst_done", {31'b0, done}, 32'h0);
      chk("midrst_result", alu_result, 32'h0);
      do_op(2'b00, 32'd2, 32'd3, lat, bcnt);
      chk("post_rst_add", alu_result, 32'd5);
      chk("post_rst_latency", lat, 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
